// File: rtl/gba_snes_pad_if.sv
// rtl/gba_snes_pad_if.sv - SNES pad wire bundle (latch, shift clock, serial data)
interface gba_snes_pad_if;
  logic pad_data;
  logic pad_latch;
  logic pad_clk;

  modport master (input pad_data, output pad_latch, output pad_clk);
  modport slave  (output pad_data, input pad_latch, input pad_clk);
endinterface

// File: rtl/gba_snes_pad.sv
// rtl/gba_snes_pad.sv - SNES gamepad poller driving registered GBA key levels
// Optional two-frame debounce: define SNES_PAD_DEBOUNCE_EN.
module gba_snes_pad #(
  parameter int HALF_CYC  = 100,
  parameter int FRAME_CYC = 1118481
) (
  input  logic                  fclk,
  input  logic                  resetn,
  gba_snes_pad_if.master        pad,
  output logic                  KeyA,
  output logic                  KeyB,
  output logic                  KeySelect,
  output logic                  KeyStart,
  output logic                  KeyRight,
  output logic                  KeyLeft,
  output logic                  KeyUp,
  output logic                  KeyDown,
  output logic                  KeyR,
  output logic                  KeyL,
  output logic                  pad_present,
  output logic                  frame_done
);

  localparam int FW = $clog2(FRAME_CYC);
  localparam int CW = $clog2(2 * HALF_CYC + 1);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(FRAME_CYC - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [15:0]   raw;
  logic [1:0]    sync;
  logic          latch_q;
  logic          clk_q;
  logic          done_q;
  logic [9:0]    keys;
  logic          present_q;
  logic          present;
  logic [9:0]    new_keys;
`ifdef SNES_PAD_DEBOUNCE_EN
  logic [10:0]   hist;
`endif

  // Key vector order {L,R,Down,Up,Left,Right,Start,Select,B,A} matches KEYINPUT.
  always_comb begin
    present  = (raw != 16'h0000);
    new_keys = 10'd0;
    if (present)
      new_keys = ~{raw[10], raw[11], raw[5], raw[4], raw[6],
                   raw[7], raw[3], raw[2], raw[0], raw[8]};
  end

  always_ff @(posedge fclk) begin
    if (!resetn) begin
      state     <= ST_LATCH;
      fcnt      <= '0;
      cnt       <= '0;
      bit_idx   <= 4'd0;
      raw       <= 16'hFFFF;
      sync      <= 2'b11;
      latch_q   <= 1'b0;
      clk_q     <= 1'b1;
      done_q    <= 1'b0;
      keys      <= 10'd0;
      present_q <= 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
      hist      <= 11'd0;
`endif
    end else begin
      sync    <= {sync[0], pad.pad_data};
      fcnt    <= (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
      // Pad pins are flops decoded from the current state: one cycle behind it.
      latch_q <= (state == ST_LATCH);
      clk_q   <= (state != ST_LOW);
      done_q  <= (state == ST_DONE);

      case (state)
        ST_IDLE: begin
          if (fcnt == FCNT_LAST) begin
            state <= ST_LATCH;
            cnt   <= '0;
          end
        end
        ST_LATCH: begin
          if (cnt == LATCH_LAST) begin
            state   <= ST_LOW;
            cnt     <= '0;
            bit_idx <= 4'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt == HALF_LAST) begin
            raw[bit_idx] <= sync[1];
            state        <= ST_HIGH;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (bit_idx == 4'd15) begin
              state <= ST_DONE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              state   <= ST_LOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // Evaluated alongside the frame_done pulse so outputs move one cycle later.
      if (done_q) begin
`ifdef SNES_PAD_DEBOUNCE_EN
        hist <= {present, new_keys};
        if (hist == {present, new_keys}) begin
          keys      <= new_keys;
          present_q <= present;
        end
`else
        keys      <= new_keys;
        present_q <= present;
`endif
      end
    end
  end

  assign pad.pad_latch = latch_q;
  assign pad.pad_clk   = clk_q;
  assign frame_done    = done_q;
  assign pad_present   = present_q;
  assign KeyA          = keys[0];
  assign KeyB          = keys[1];
  assign KeySelect     = keys[2];
  assign KeyStart      = keys[3];
  assign KeyRight      = keys[4];
  assign KeyLeft       = keys[5];
  assign KeyUp         = keys[6];
  assign KeyDown       = keys[7];
  assign KeyR          = keys[8];
  assign KeyL          = keys[9];

endmodule

// File: tb/tb_gba_snes_pad.sv
// tb/tb_gba_snes_pad.sv - directed bench for gba_snes_pad with a shift-register pad model
module tb_gba_snes_pad;

  localparam int HALF = 4;
  localparam int FRAME = 200;
`ifdef SNES_PAD_DEBOUNCE_EN
  localparam int NF = 2;
`else
  localparam int NF = 1;
`endif

  logic fclk = 1'b0;
  logic resetn = 1'b0;
  logic KeyA, KeyB, KeySelect, KeyStart, KeyRight, KeyLeft, KeyUp, KeyDown, KeyR, KeyL;
  logic pad_present, frame_done;
  logic [15:0] word = 16'hFFFF;
  logic pd = 1'b1;
  int   idx = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  gba_snes_pad_if pif ();
  assign pif.pad_data = pd;

  gba_snes_pad #(.HALF_CYC(HALF), .FRAME_CYC(FRAME)) dut (
    .fclk(fclk), .resetn(resetn), .pad(pif.master),
    .KeyA(KeyA), .KeyB(KeyB), .KeySelect(KeySelect), .KeyStart(KeyStart),
    .KeyRight(KeyRight), .KeyLeft(KeyLeft), .KeyUp(KeyUp), .KeyDown(KeyDown),
    .KeyR(KeyR), .KeyL(KeyL), .pad_present(pad_present), .frame_done(frame_done)
  );

  always #5 fclk = ~fclk;

  // Pad: latch loads the word and shows bit 0; each pad_clk rise shifts.
  always @(posedge pif.pad_latch or posedge pif.pad_clk) begin
    if (pif.pad_latch) idx = 0;
    else               idx = idx + 1;
    pd = (idx < 16) ? word[idx] : 1'b1;
  end

  function automatic logic [9:0] keyvec();
    return {KeyL, KeyR, KeyDown, KeyUp, KeyLeft, KeyRight, KeyStart, KeySelect, KeyB, KeyA};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    @(negedge fclk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < FRAME + 50; i++) begin
      tick();
      if (frame_done) break;
    end
    check("wait_done", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) wait_done();
    tick();
  endtask

  int  latch_cnt, latch_first, low_pulses, low_cycles, done_at, done_cnt, next_rise;
  logic prev_latch, prev_clk;

  initial begin
    repeat (3) tick();
    check("rst_latch", {31'd0, pif.pad_latch}, 32'd0);
    check("rst_clk", {31'd0, pif.pad_clk}, 32'd1);
    check("rst_keys", {22'd0, keyvec()}, 32'd0);
    check("rst_present", {31'd0, pad_present}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);

    // Trace the first frame; cycle 0 is the first cycle after release.
    resetn = 1'b1;
    latch_cnt = 0; latch_first = -1; low_pulses = 0; low_cycles = 0;
    done_at = -1; done_cnt = 0; next_rise = -1;
    prev_latch = 1'b0; prev_clk = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      tick();
      if (k < FRAME && pif.pad_latch) begin
        latch_cnt++;
        if (latch_first < 0) latch_first = k;
      end
      if (k >= 8 && pif.pad_latch && !prev_latch && next_rise < 0) next_rise = k;
      if (!pif.pad_clk) low_cycles++;
      if (!pif.pad_clk && prev_clk) low_pulses++;
      if (frame_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      prev_latch = pif.pad_latch;
      prev_clk = pif.pad_clk;
    end
    check("latch_first", latch_first, 0);
    check("latch_len", latch_cnt, 8);
    check("clk_pulses", low_pulses, 16);
    check("clk_low_cycles", low_cycles, 64);
    check("done_cycle", done_at, 136);
    check("done_count", done_cnt, 1);
    check("next_latch", next_rise, 200);

    run_frames(1);
    check("idle_keys", {22'd0, keyvec()}, 32'd0);
    check("idle_present", {31'd0, pad_present}, 32'd1);

    word = 16'hF6FF;
`ifdef SNES_PAD_DEBOUNCE_EN
    run_frames(1);
    check("ar_first_frame", {22'd0, keyvec()}, 32'h000);
`endif
    run_frames(1);
    check("ar_keys", {22'd0, keyvec()}, 32'h101);
    check("ar_present", {31'd0, pad_present}, 32'd1);

    word = 16'hFFFF;
    run_frames(NF);
    check("release_keys", {22'd0, keyvec()}, 32'h000);
    word = 16'hFFFE;
    run_frames(1);
`ifdef SNES_PAD_DEBOUNCE_EN
    check("glitch_b", {22'd0, keyvec()}, 32'h000);
`else
    check("b_keys", {22'd0, keyvec()}, 32'h002);
`endif
    word = 16'hFFFF;
    run_frames(1);
    check("b_released", {31'd0, KeyB}, 32'd0);

    word = 16'h0000;
    run_frames(NF);
    check("float_keys", {22'd0, keyvec()}, 32'h000);
    check("float_present", {31'd0, pad_present}, 32'd0);

    word = 16'hAAAA;
    run_frames(NF);
    check("alt_raw", {16'd0, dut.raw}, 32'hAAAA);
    check("alt_keys", {22'd0, keyvec()}, 32'h267);
    check("alt_present", {31'd0, pad_present}, 32'd1);

    // Reset in the middle of bit 7's low phase.
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      if (pif.pad_latch) break;
    end
    check("latch_seen", {31'd0, pif.pad_latch}, 32'd1);
    repeat (65) tick();
    check("bit7_low", {31'd0, pif.pad_clk}, 32'd0);
    resetn = 1'b0;
    tick();
    check("mid_rst_clk", {31'd0, pif.pad_clk}, 32'd1);
    check("mid_rst_latch", {31'd0, pif.pad_latch}, 32'd0);
    check("mid_rst_keys", {22'd0, keyvec()}, 32'h000);
    check("mid_rst_present", {31'd0, pad_present}, 32'd0);
    tick();
    check("mid_rst_hold", {31'd0, pif.pad_latch}, 32'd0);
    resetn = 1'b1;
    tick();
    check("restart_latch", {31'd0, pif.pad_latch}, 32'd1);
    run_frames(NF);
    check("restart_keys", {22'd0, keyvec()}, 32'h267);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
